// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between NUM_REQ requesters.
// Define MEM_ARB_FIXED_PRIORITY_EN for fixed priority (lowest active index always wins).
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for a request; arbitrates and latches the winner
// S_ACCESS | memory port driven; access happens on the closing edge
// S_WAIT   | memory read data settles; captured into rdata at the end
// S_DONE   | ack pulse to the winner, rdata valid
module memory_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_data_in,
  input  logic [DATA_W-1:0]         mem_data_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t               r_state;
  logic [IDX_W-1:0]     r_winner;
  logic [NUM_REQ-1:0]   r_ack;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_busy;
  logic                 r_mem_write;
  logic [ADDR_W-1:0]    r_mem_address;
  logic [DATA_W-1:0]    r_mem_data_in;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
  logic [IDX_W-1:0]     r_last;
`endif

  logic                 w_any;
  logic [IDX_W-1:0]     w_winner;
  logic                 w_wr;
  logic [ADDR_W-1:0]    w_addr;
  logic [DATA_W-1:0]    w_data;

  assign w_any = |req;

  always_comb begin : p_pick
`ifndef MEM_ARB_FIXED_PRIORITY_EN
    int   v_idx;
    logic v_hit;
    v_hit = 1'b0;
    v_idx = 0;
`endif
    w_winner = '0;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) w_winner = IDX_W'(i);
    end
`else
    // search starts just after the last winner and wraps
    for (int i = 1; i <= NUM_REQ; i++) begin
      v_idx = (int'(r_last) + i) % NUM_REQ;
      if (!v_hit && req[IDX_W'(v_idx)]) begin
        v_hit    = 1'b1;
        w_winner = IDX_W'(v_idx);
      end
    end
`endif
  end

  always_comb begin
    w_wr   = 1'b0;
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == w_winner) begin
        w_wr   = req_write[i];
        w_addr = req_address[i*ADDR_W +: ADDR_W];
        w_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_winner      <= '0;
      r_ack         <= '0;
      r_rdata       <= '0;
      r_busy        <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      r_last        <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_winner      <= w_winner;
            r_mem_write   <= w_wr;
            r_mem_address <= w_addr;
            r_mem_data_in <= w_data;
            r_busy        <= 1'b1;
            r_state       <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_mem_write <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          // memory returns post-write data, so writes echo the new value here
          r_rdata         <= mem_data_out;
          r_ack[r_winner] <= 1'b1;
          r_state         <= S_DONE;
        end
        S_DONE: begin
`ifndef MEM_ARB_FIXED_PRIORITY_EN
          r_last  <= r_winner;
`endif
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign busy        = r_busy;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural 8x4 synchronous memory (read-after-write).
// Expectations for MEM_ARB_FIXED_PRIORITY_EN builds are selected by the same macro.
module tb_memory_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 4;

  logic                      clock = 1'b0;
  logic                      reset_n = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ-1:0]        req_write = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_address = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic                      mem_write;
  logic [ADDR_W-1:0]         mem_address;
  logic [DATA_W-1:0]         mem_data_in;
  logic [DATA_W-1:0]         mem_data_out = '0;

  logic [DATA_W-1:0]         mem [0:7];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [NUM_REQ-1:0] ack_log [0:7];
  logic [DATA_W-1:0]  rd_log  [0:7];
  int                 cyc_log [0:7];

  memory_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req          (req),
    .req_write    (req_write),
    .req_address  (req_address),
    .req_data     (req_data),
    .ack          (ack),
    .rdata        (rdata),
    .busy         (busy),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial for (int i = 0; i < 8; i++) mem[i] = '0;

  always @(posedge clock) begin
    if (mem_write) begin
      mem[mem_address] <= mem_data_in;
      mem_data_out     <= mem_data_in;
    end else begin
      mem_data_out <= mem[mem_address];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data);
    req[idx]                          = 1'b1;
    req_write[idx]                    = wr;
    req_address[idx*ADDR_W +: ADDR_W] = addr;
    req_data[idx*DATA_W +: DATA_W]    = data;
  endtask

  // single transaction, driven from a negedge while the arbiter is idle
  task automatic do_txn(input string tag, input int idx, input logic wr,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                        input logic [DATA_W-1:0] exp_rd);
    int  nwr;
    bit  found;
    nwr   = 0;
    found = 0;
    set_req(idx, wr, addr, data);
    for (int c = 1; c <= 10 && !found; c++) begin
      @(negedge clock);
      if (mem_write) nwr++;
      if (c == 1) begin
        check_val({tag, "_addr"}, 32'(mem_address), 32'(addr));
        check_val({tag, "_wr"}, 32'(mem_write), 32'(wr));
        if (wr) check_val({tag, "_din"}, 32'(mem_data_in), 32'(data));
      end
      if (ack != '0) begin
        found = 1;
        check_val({tag, "_lat"}, 32'(c), 32'd3);
        check_val({tag, "_ack"}, 32'(ack), 32'(1 << idx));
        check_val({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
        req[idx] = 1'b0;
      end
    end
    if (!found) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    check_val({tag, "_nwr"}, 32'(nwr), wr ? 32'd1 : 32'd0);
    @(negedge clock);
    check_val({tag, "_ack_off"}, 32'(ack), 32'd0);
    check_val({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // log the next n ack pulses, bounded
  task automatic collect(input string tag, input int n);
    int got;
    got = 0;
    for (int c = 0; c < 12 * n && got < n; c++) begin
      @(negedge clock);
      if (ack != '0) begin
        ack_log[got] = ack;
        rd_log[got]  = rdata;
        cyc_log[got] = cyc;
        got++;
      end
    end
    if (got < n) check_val({tag, "_timeout"}, 32'(got), 32'(n));
  endtask

  initial begin
    logic [NUM_REQ-1:0] exp4 [0:3];
    logic [DATA_W-1:0]  exr4 [0:3];
    logic [NUM_REQ-1:0] exp6 [0:2];

    #1;
    check_val("rst_ack", 32'(ack), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_memwr", 32'(mem_write), 32'd0);
    check_val("rst_rdata", 32'(rdata), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // write then read back through the other port
    do_txn("t2_wr", 0, 1'b1, 3'd5, 4'hA, 4'hA);
    do_txn("t3_rd5", 1, 1'b0, 3'd5, 4'h0, 4'hA);
    do_txn("t3_rd3", 1, 1'b0, 3'd3, 4'h0, 4'h0);

    // both held: req0 reads addr 2, req1 writes 3 to addr 2
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    exp4 = '{2'b01, 2'b01, 2'b01, 2'b01};
    exr4 = '{4'h0, 4'h0, 4'h0, 4'h0};
`else
    exp4 = '{2'b01, 2'b10, 2'b01, 2'b10};
    exr4 = '{4'h0, 4'h3, 4'h3, 4'h3};
`endif
    set_req(0, 1'b0, 3'd2, 4'h0);
    set_req(1, 1'b1, 3'd2, 4'h3);
    collect("t4", 4);
    req = '0;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t4_ack%0d", i), 32'(ack_log[i]), 32'(exp4[i]));
      check_val($sformatf("t4_rd%0d", i), 32'(rd_log[i]), 32'(exr4[i]));
      if (i > 0) check_val($sformatf("t4_gap%0d", i), 32'(cyc_log[i] - cyc_log[i-1]), 32'd4);
    end
    @(negedge clock);
    @(negedge clock);

    // reset during ACCESS abandons the write
    set_req(0, 1'b1, 3'd7, 4'hF);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("t5_memwr", 32'(mem_write), 32'd0);
    check_val("t5_ack", 32'(ack), 32'd0);
    check_val("t5_busy", 32'(busy), 32'd0);
    check_val("t5_addr", 32'(mem_address), 32'd0);
    check_val("t5_din", 32'(mem_data_in), 32'd0);
    check_val("t5_rdata", 32'(rdata), 32'd0);
    @(negedge clock);
    req = '0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    set_req(0, 1'b0, 3'd7, 4'h0);
    set_req(1, 1'b0, 3'd7, 4'h0);
    collect("t5a", 1);
    req[0] = 1'b0;
    check_val("t5_first", 32'(ack_log[0]), 32'b01);
    check_val("t5_rd7a", 32'(rd_log[0]), 32'd0);
    collect("t5b", 1);
    req = '0;
    check_val("t5_second", 32'(ack_log[0]), 32'b10);
    check_val("t5_rd7b", 32'(rd_log[0]), 32'd0);
    @(negedge clock);
    @(negedge clock);

    // priority mode: both held, then drop req0
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    exp6 = '{2'b01, 2'b01, 2'b01};
`else
    exp6 = '{2'b01, 2'b10, 2'b01};
`endif
    set_req(0, 1'b0, 3'd1, 4'h0);
    set_req(1, 1'b0, 3'd1, 4'h0);
    collect("t6", 3);
    req[0] = 1'b0;
    for (int i = 0; i < 3; i++)
      check_val($sformatf("t6_ack%0d", i), 32'(ack_log[i]), 32'(exp6[i]));
    collect("t6b", 1);
    req = '0;
    check_val("t6_req1", 32'(ack_log[0]), 32'b10);
    @(negedge clock);
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
